// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the intersection sensors/lamps and the phase scheduler.
// master = sensor/lamp side, slave = the scheduler itself.
interface traffic_phase_scheduler_if;
  logic       i_req_ns;
  logic       i_req_ew;
  logic       i_ped_btn;
  logic [5:0] o_light;
  logic [2:0] o_phase;
  logic       o_walk;
  logic       o_ped_pend;

  modport master (
    output i_req_ns,
    output i_req_ew,
    output i_ped_btn,
    input  o_light,
    input  o_phase,
    input  o_walk,
    input  o_ped_pend
  );

  modport slave (
    input  i_req_ns,
    input  i_req_ew,
    input  i_ped_btn,
    output o_light,
    output o_phase,
    output o_walk,
    output o_ped_pend
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven NS/EW phase scheduler with min/max green, yellow and all-red timing.
// Define PED_WALK_EN to enable the pedestrian request latch and the WALK phase.
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 5,
  parameter int CNT_W     = 4
) (
  input logic                      i_clk,
  input logic                      i_rst_n,
  traffic_phase_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR_NS = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR_EW = 3'd5,
    WALK  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_next;
  logic             last_dir;        // 0: NS had the last green, 1: EW
  logic             last_dir_next;
  logic             ped_pend;
  logic             in_green;
  logic             state_change;

  assign in_green     = (state == NS_G) || (state == EW_G);
  assign state_change = (next_state != state);

  // Next-state decision. Vehicle requests only matter at the green-exit test.
  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      NS_G: begin
        if ((bus.i_req_ew || ped_pend) &&
            (((timer >= MIN_LAST) && !bus.i_req_ns) || (timer == MAX_LAST)))
          next_state = NS_Y;
      end
      NS_Y: begin
        if (timer == YEL_LAST) next_state = AR_NS;
      end
      AR_NS: begin
        if (timer == AR_LAST) next_state = ped_pend ? WALK : EW_G;
      end
      EW_G: begin
        if ((bus.i_req_ns || ped_pend) &&
            (((timer >= MIN_LAST) && !bus.i_req_ew) || (timer == MAX_LAST)))
          next_state = EW_Y;
      end
      EW_Y: begin
        if (timer == YEL_LAST) next_state = AR_EW;
      end
      AR_EW: begin
        if (timer == AR_LAST) next_state = ped_pend ? WALK : NS_G;
      end
      WALK: begin
        if (timer == WALK_LAST) next_state = last_dir ? NS_G : EW_G;
      end
      default: next_state = NS_G;
    endcase
  end

  // Timer restarts on each phase change; a resting green parks it at MAX_LAST
  // so a late-arriving opposing request can max-out on the very next edge.
  always_comb begin
    timer_next = timer + CNT_W'(1);
    if (state_change)
      timer_next = '0;
    else if (in_green && (timer == MAX_LAST))
      timer_next = timer;
  end

  always_comb begin
    last_dir_next = last_dir;
    if (state_change && (next_state == NS_G))
      last_dir_next = 1'b0;
    else if (state_change && (next_state == EW_G))
      last_dir_next = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= NS_G;
      timer    <= '0;
      last_dir <= 1'b0;
    end else begin
      state    <= next_state;
      timer    <= timer_next;
      last_dir <= last_dir_next;
    end
  end

`ifdef PED_WALK_EN
  logic ped_pend_next;

  // A press on the cycle that enters WALK is dropped; presses during WALK are ignored.
  always_comb begin
    ped_pend_next = ped_pend;
    if (state_change && (next_state == WALK))
      ped_pend_next = 1'b0;
    else if (bus.i_ped_btn && (state != WALK))
      ped_pend_next = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      ped_pend <= 1'b0;
    else
      ped_pend <= ped_pend_next;
  end

  assign bus.o_walk     = (state == WALK);
  assign bus.o_ped_pend = ped_pend;
`else
  logic unused_ped_btn;

  assign unused_ped_btn = bus.i_ped_btn;
  assign ped_pend       = 1'b0;
  assign bus.o_walk     = 1'b0;
  assign bus.o_ped_pend = 1'b0;
`endif

  // Moore output decode: {NS_R,NS_Y,NS_G,EW_R,EW_Y,EW_G}.
  always_comb begin
    bus.o_light = 6'b100100;
    case (state)
      NS_G:    bus.o_light = 6'b001100;
      NS_Y:    bus.o_light = 6'b010100;
      EW_G:    bus.o_light = 6'b100001;
      EW_Y:    bus.o_light = 6'b100010;
      default: bus.o_light = 6'b100100;
    endcase
  end

  assign bus.o_phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler; cycle k is sampled at the falling
// edge after k rising edges following reset release.
module tb_traffic_phase_scheduler;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  traffic_phase_scheduler_if bus ();

  traffic_phase_scheduler dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] light_of(input int code);
    case (code)
      0:       return 6'b001100;
      1:       return 6'b010100;
      3:       return 6'b100001;
      4:       return 6'b100010;
      default: return 6'b100100;
    endcase
  endfunction

  // Phase sequence with both roads requesting continuously: 10+3+1+10+3+1 = 28.
  function automatic int both_phase(input int c);
    int m;
    m = c % 28;
    if (m < 10) return 0;
    if (m < 13) return 1;
    if (m < 14) return 2;
    if (m < 24) return 3;
    if (m < 27) return 4;
    return 5;
  endfunction

  task automatic start(input logic ns, input logic ew);
    rst_n        = 1'b0;
    bus.i_req_ns = ns;
    bus.i_req_ew = ew;
    bus.i_ped_btn = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp2 [9];
    n_tests = 0;
    n_fail  = 0;
    exp2 = '{0, 0, 0, 0, 1, 1, 1, 2, 3};

    // Reset state and idle rest in NS_G.
    start(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst light", bus.o_light, 6'b001100);
    check("rst phase", bus.o_phase, 3'd0);
    check("rst walk", bus.o_walk, 1'b0);
    check("rst ped_pend", bus.o_ped_pend, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      check($sformatf("idle c%0d", c), {bus.o_phase, bus.o_light}, {3'd0, 6'b001100});
      @(negedge clk);
    end

    // EW demand only: gap-out at MIN_GREEN, then EW rests until NS arrives.
    start(1'b0, 1'b1);
    for (int c = 0; c <= 21; c++) begin
      if (c < 9)
        check($sformatf("ew_only c%0d phase", c), bus.o_phase, exp2[c]);
      if (c == 4) check("ew_only c4 light", bus.o_light, 6'b010100);
      if (c == 7) check("ew_only c7 light", bus.o_light, 6'b100100);
      if (c == 8) check("ew_only c8 light", bus.o_light, 6'b100001);
      if (c == 20) begin
        check("ew_only rest c20", bus.o_phase, 3'd3);
        bus.i_req_ns = 1'b1;
      end
      if (c == 21) check("ew_only maxout c21", bus.o_phase, 3'd4);
      @(negedge clk);
    end

    // Both roads held: strict alternation, 10-cycle greens, period 28.
    start(1'b1, 1'b1);
    for (int c = 0; c < 60; c++) begin
      check($sformatf("both c%0d", c), {bus.o_phase, bus.o_light},
            {3'(both_phase(c)), light_of(both_phase(c))});
      @(negedge clk);
    end

    // Own road drops mid-green after MIN_GREEN: gap-out on the next edge.
    start(1'b1, 1'b1);
    for (int c = 0; c <= 7; c++) begin
      if (c == 6) bus.i_req_ns = 1'b0;
      check($sformatf("gap c%0d", c), bus.o_phase, (c < 7) ? 0 : 1);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of EW_Y.
    start(1'b1, 1'b1);
    for (int c = 0; c < 25; c++) begin
      bus.i_ped_btn = (c == 20);
      @(negedge clk);
    end
    check("pre_rst phase EW_Y", bus.o_phase, 3'd4);
`ifdef PED_WALK_EN
    check("pre_rst ped_pend", bus.o_ped_pend, 1'b1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst light", bus.o_light, 6'b001100);
    check("mid_rst phase", bus.o_phase, 3'd0);
    check("mid_rst ped_pend", bus.o_ped_pend, 1'b0);
    @(negedge clk);

`ifdef PED_WALK_EN
    // Pedestrian pulse at cycle 2; presses at 7 (entering WALK) and 9 (in WALK) are dropped.
    start(1'b0, 1'b0);
    for (int c = 0; c <= 16; c++) begin
      bus.i_ped_btn = (c == 2) || (c == 7) || (c == 9);
      if (c == 2) check("ped c2 pend", bus.o_ped_pend, 1'b0);
      if (c == 3) begin
        check("ped c3 pend", bus.o_ped_pend, 1'b1);
        check("ped c3 phase", bus.o_phase, 3'd0);
      end
      if (c == 4) check("ped c4 phase", bus.o_phase, 3'd1);
      if (c == 7) check("ped c7 phase", bus.o_phase, 3'd2);
      if (c >= 8 && c <= 12) begin
        check($sformatf("ped c%0d walk", c), {bus.o_phase, bus.o_walk, bus.o_light},
              {3'd6, 1'b1, 6'b100100});
        check($sformatf("ped c%0d pend", c), bus.o_ped_pend, 1'b0);
      end
      if (c == 13) check("ped c13 ew_g", {bus.o_phase, bus.o_walk, bus.o_light},
                         {3'd3, 1'b0, 6'b100001});
      if (c == 16) check("ped c16 rest", bus.o_phase, 3'd3);
      @(negedge clk);
    end
`else
    // Button ignored entirely when pedestrian logic is disabled.
    start(1'b0, 1'b0);
    bus.i_ped_btn = 1'b1;
    for (int c = 0; c < 30; c++) begin
      check($sformatf("noped c%0d", c), {bus.o_phase, bus.o_walk, bus.o_ped_pend},
            {3'd0, 1'b0, 1'b0});
      @(negedge clk);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
